dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the byte-addressed data memory (`dmem`, 4 byte banks, unaligned-capable).
- Shares the single dmem port between requester 0 (core load/store unit) and requester 1 (loader/debug/DMA master).
- Registers the granted command and drives dmem for one cycle.
- Returns load data, sign- or zero-extended per size, with a registered valid pulse.

Parameters:
- DMEM_ADDR_WIDTH, 12, byte address width; must match dmem.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req0 / req1  input  1  request valid, requester 0 / 1
- we0 / we1  input  1  1 = store, 0 = load
- sz0 / sz1  input  2  size: 00 byte, 01 half, 10 word (11 treated as word)
- uns0 / uns1  input  1  load zero-extend (LBU/LHU); ignored for stores and words
- addr0 / addr1  input  DMEM_ADDR_WIDTH  byte address
- wdata0 / wdata1  input  32  store data, right-aligned
- gnt0 / gnt1  output  1  combinational grant; request accepted when req&&gnt
- rvalid0 / rvalid1  output  1  registered one-cycle load-response pulse
- rdata0 / rdata1  output  32  extended load data; held until next response to that port
- err0 / err1  output  1  registered error pulse (optional feature only; else tied 0)
- mem_addr  output  DMEM_ADDR_WIDTH  to dmem addr
- mem_rd_en  output  1  to dmem rd_en
- mem_wr_en  output  1  to dmem wr_en
- mem_sz  output  2  to dmem sz
- mem_din  output  32  to dmem din
- mem_dout  input  32  from dmem dout (combinational read, addressed byte in [7:0])

Behaviour:
- Reset (async, rst_n=0): all outputs 0; cmd_v=0; last_gnt=1, so port 0 wins first; rdata registers cleared.
- Pipeline, one request per cycle maximum:
  - Cycle T (ARB): at most one gnt high.
  - Edge ending T: winner's we/sz/uns/addr/wdata/port-id captured into the command register; cmd_v=1.
  - Cycle T+1 (ACCESS): mem_* driven from the command register. mem_wr_en=cmd_v&&we; mem_rd_en=cmd_v&&!we.
  - Store: written to dmem at the edge ending T+1. No response is returned for stores.
  - Load: mem_dout extended and captured at the edge ending T+1. rvalidN=1 during T+2 only.
  - cmd_v=0 in cycles with no grant; mem_rd_en and mem_wr_en are then 0, and mem_addr/mem_din hold their last value.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active: round-robin; the port not granted last (per last_gnt) wins. last_gnt updates only on an actual grant.
  - A requester continuously asserting is served within 2 cycles.
  - No back-pressure from dmem, so a grant is always available every cycle.
- Load extension on mem_dout[31:0] (d):
  - byte: uns ? {24'b0, d[7:0]} : {{24{d[7]}}, d[7:0]}
  - half: uns ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]}
  - word: d
- Ordering:
  - Store at T followed by load to the same address at T+1, from either port, returns the new data. The write commits before the read-access cycle.
  - Back-to-back loads from one port yield back-to-back rvalid pulses in order.
- Requester obligation: hold req/fields stable until gnt; deasserting before gnt is permitted (request dropped).
- Reset mid-operation: a pending command is discarded; no write issued after rst_n falls; no rvalid after reset.

Optional Feature:
- Macro DMEM_ARB_ALIGN_CHK_EN.
- Defined:
  - A granted request with half at addr[0]=1 or word at addr[1:0]!=0 is still granted and pipelined.
  - In ACCESS it does not drive mem_rd_en/mem_wr_en; no memory change.
  - errN pulses at T+2 for the misaligned port. For a misaligned load, rvalidN stays 0 and rdataN is unchanged.
- Undefined: no check; unaligned accesses pass to dmem (which supports them); err0/err1 tied 0.

Test Plan:
- Reset, then req0 store word 0xDEADBEEF @0x010, then req0 load word @0x010 → gnt0 both cycles; rvalid0 at T+2, rdata0=0xDEADBEEF.
- Byte 0x80 stored @0x013; load byte signed → rdata=0xFFFFFF80; load unsigned → 0x00000080. Half 0x8001 stored @0x020: signed load → 0xFFFF8001, unsigned load → 0x00008001.
- req0 and req1 both held as loads for 4 cycles → grants alternate 0,1,0,1; rvalid pulses alternate accordingly, each with its own address's data.
- req1 store 0x11223344 @0x040 at T, req0 load word @0x040 at T+1 → rdata0=0x11223344.
- rst_n pulled low in the ACCESS cycle of a store 0xAAAAAAAA @0x050, over prior 0 → after reset, load @0x050 returns 0; all outputs 0 during reset.
- With DMEM_ARB_ALIGN_CHK_EN: load word @0x012 → err0 at T+2, no rvalid0, mem_rd_en stays 0. Without the macro: data from bytes 0x012..0x015 is returned.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and one-cycle access sequencer in front of dmem.
// Ports: req/we/sz/uns/addr/wdata per requester in, gnt/rvalid/rdata/err per requester out, mem_* to dmem; option DMEM_ARB_ALIGN_CHK_EN.
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0,
  input  logic                       req1,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [1:0]                 sz0,
  input  logic [1:0]                 sz1,
  input  logic                       uns0,
  input  logic                       uns1,
  input  logic [DMEM_ADDR_WIDTH-1:0] addr0,
  input  logic [DMEM_ADDR_WIDTH-1:0] addr1,
  input  logic [31:0]                wdata0,
  input  logic [31:0]                wdata1,
  output logic                       gnt0,
  output logic                       gnt1,
  output logic                       rvalid0,
  output logic                       rvalid1,
  output logic [31:0]                rdata0,
  output logic [31:0]                rdata1,
  output logic                       err0,
  output logic                       err1,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                       mem_rd_en,
  output logic                       mem_wr_en,
  output logic [1:0]                 mem_sz,
  output logic [31:0]                mem_din,
  input  logic [31:0]                mem_dout
);

  typedef struct packed {
    logic                       we;
    logic [1:0]                 sz;
    logic                       uns;
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [31:0]                wdata;
    logic                       port;
  } cmd_t;

  cmd_t        cmd;
  cmd_t        nxt;
  logic        cmd_v;
  logic        last_gnt;
  logic        acc_ok;
  logic        ld_ok;
  logic [31:0] ext;

  // last_gnt names the port served last; on contention the other wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = last_gnt;
      gnt1 = !last_gnt;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_comb begin
    nxt = '0;
    if (gnt1) begin
      nxt = '{we1, sz1, uns1, addr1, wdata1, 1'b1};
    end else begin
      nxt = '{we0, sz0, uns0, addr0, wdata0, 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_v    <= 1'b0;
      cmd      <= '0;
      last_gnt <= 1'b1;
    end else begin
      cmd_v <= gnt0 || gnt1;
      if (gnt0 || gnt1) begin
        cmd      <= nxt;
        last_gnt <= gnt1;
      end
    end
  end

`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic mis;

  // size 11 is treated as word, so sz[1] selects the word check
  assign mis = ((cmd.sz == 2'b01) && cmd.addr[0])
            || (cmd.sz[1] && (cmd.addr[1:0] != 2'b00));
  assign acc_ok = cmd_v && !mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      err0 <= cmd_v && mis && !cmd.port;
      err1 <= cmd_v && mis && cmd.port;
    end
  end
`else
  assign acc_ok = cmd_v;
  assign err0   = 1'b0;
  assign err1   = 1'b0;
`endif

  assign ld_ok     = acc_ok && !cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_sz    = cmd.sz;
  assign mem_din   = cmd.wdata;
  assign mem_wr_en = acc_ok && cmd.we;
  assign mem_rd_en = ld_ok;

  always_comb begin
    ext = mem_dout;
    unique case (1'b1)
      (cmd.sz == 2'b00): begin
        ext = cmd.uns ? {24'b0, mem_dout[7:0]}
                      : {{24{mem_dout[7]}}, mem_dout[7:0]};
      end
      (cmd.sz == 2'b01): begin
        ext = cmd.uns ? {16'b0, mem_dout[15:0]}
                      : {{16{mem_dout[15]}}, mem_dout[15:0]};
      end
      default: ext = mem_dout;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= ld_ok && !cmd.port;
      rvalid1 <= ld_ok && cmd.port;
      if (ld_ok && !cmd.port) rdata0 <= ext;
      if (ld_ok && cmd.port) rdata1 <= ext;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a byte-array dmem model.
// Drives #1 after posedge, samples on negedge.
module tb_dmem_arbiter;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1, uns0, uns1;
  logic [1:0]    sz0, sz1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0]   rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, mem_wr_en;
  logic [1:0]    mem_sz;
  logic [31:0]   mem_din, mem_dout;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [4096];

  always #5 clk = ~clk;

  dmem_arbiter #(.DMEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .sz0(sz0), .sz1(sz1), .uns0(uns0), .uns1(uns1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_sz(mem_sz),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  logic [AW-1:0] a1, a2, a3;
  assign a1 = mem_addr + AW'(1);
  assign a2 = mem_addr + AW'(2);
  assign a3 = mem_addr + AW'(3);
  assign mem_dout = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_din[7:0];
      if (mem_sz != 2'b00) mem[a1] <= mem_din[15:8];
      if (mem_sz[1]) begin
        mem[a2] <= mem_din[23:16];
        mem[a3] <= mem_din[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit p, input bit we, input logic [1:0] sz,
                       input bit uns, input logic [AW-1:0] a,
                       input logic [31:0] wd);
    if (!p) begin
      req0 = 1; we0 = we; sz0 = sz; uns0 = uns; addr0 = a; wdata0 = wd;
    end else begin
      req1 = 1; we1 = we; sz1 = sz; uns1 = uns; addr1 = a; wdata1 = wd;
    end
  endtask

  task automatic do_op(input string tag, input bit p, input bit we,
                       input logic [1:0] sz, input bit uns,
                       input logic [AW-1:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    drive(p, we, sz, uns, a, wd);
    @(negedge clk);
    chk({tag, ".gnt"}, {31'b0, p ? gnt1 : gnt0}, 1);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk({tag, ".en"}, {31'b0, we ? mem_wr_en : mem_rd_en}, 1);
  endtask

  task automatic do_ld(input string tag, input bit p, input logic [1:0] sz,
                       input bit uns, input logic [AW-1:0] a,
                       input logic [31:0] exp);
    do_op(tag, p, 1'b0, sz, uns, a, 32'h0);
    @(negedge clk);
    chk({tag, ".rv"}, {31'b0, p ? rvalid1 : rvalid0}, 1);
    chk({tag, ".rd"}, p ? rdata1 : rdata0, exp);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst_n = 0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; uns0 = 0; uns1 = 0;
    sz0 = 0; sz1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(negedge clk);
    chk("rst.outs", {rvalid0, rvalid1, err0, err1, mem_rd_en, mem_wr_en,
                     gnt0, gnt1}, 0);
    chk("rst.rdata0", rdata0, 0);
    chk("rst.maddr", {20'b0, mem_addr}, 0);
    @(posedge clk); #1;
    rst_n = 1;

    do_op("st_w", 0, 1, 2'b10, 0, 12'h010, 32'hDEADBEEF);
    do_ld("ld_w", 0, 2'b10, 0, 12'h010, 32'hDEADBEEF);
    do_op("st_b", 0, 1, 2'b00, 0, 12'h013, 32'h00000080);
    do_ld("ld_b", 0, 2'b00, 0, 12'h013, 32'hFFFFFF80);
    do_ld("ld_bu", 0, 2'b00, 1, 12'h013, 32'h00000080);
    do_op("st_h", 1, 1, 2'b01, 0, 12'h020, 32'h00008001);
    do_ld("ld_h", 1, 2'b01, 0, 12'h020, 32'hFFFF8001);
    do_ld("ld_hu", 0, 2'b01, 1, 12'h020, 32'h00008001);

    // misaligned word: bytes 12..15 are AD,80,00,00
    @(posedge clk); #1;
    drive(0, 0, 2'b10, 0, 12'h012, 0);
    @(negedge clk);
    chk("mis.gnt", {31'b0, gnt0}, 1);
    @(posedge clk); #1;
    req0 = 0;
    @(negedge clk);
`ifdef DMEM_ARB_ALIGN_CHK_EN
    chk("mis.rden", {31'b0, mem_rd_en}, 0);
    @(negedge clk);
    chk("mis.err", {31'b0, err0}, 1);
    chk("mis.rv", {31'b0, rvalid0}, 0);
    chk("mis.rd", rdata0, 32'h00008001);
`else
    chk("mis.rden", {31'b0, mem_rd_en}, 1);
    @(negedge clk);
    chk("mis.err", {31'b0, err0}, 0);
    chk("mis.rv", {31'b0, rvalid0}, 1);
    chk("mis.rd", rdata0, 32'h000080AD);
`endif

    // preload; last grant goes to port 1 so port 0 wins first
    do_op("pre0", 0, 1, 2'b10, 0, 12'h100, 32'h0A0A0A0A);
    do_op("pre1", 1, 1, 2'b10, 0, 12'h104, 32'h1B1B1B1B);
    @(posedge clk); #1;
    drive(0, 0, 2'b10, 0, 12'h100, 0);
    drive(1, 0, 2'b10, 0, 12'h104, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk($sformatf("rr.g0.%0d", k), {31'b0, gnt0}, (k % 2 == 0));
        chk($sformatf("rr.g1.%0d", k), {31'b0, gnt1}, (k % 2 == 1));
      end
      if (k >= 2) begin
        chk($sformatf("rr.v0.%0d", k), {31'b0, rvalid0}, (k % 2 == 0));
        chk($sformatf("rr.v1.%0d", k), {31'b0, rvalid1}, (k % 2 == 1));
        if (k % 2 == 0) chk("rr.d0", rdata0, 32'h0A0A0A0A);
        else chk("rr.d1", rdata1, 32'h1B1B1B1B);
      end
      @(posedge clk); #1;
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
    end

    // store from port 1, load from port 0 in the next cycle
    drive(1, 1, 2'b10, 0, 12'h040, 32'h11223344);
    @(negedge clk);
    chk("fw.gnt1", {31'b0, gnt1}, 1);
    @(posedge clk); #1;
    req1 = 0;
    drive(0, 0, 2'b10, 0, 12'h040, 0);
    @(negedge clk);
    chk("fw.gnt0", {31'b0, gnt0}, 1);
    @(posedge clk); #1;
    req0 = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("fw.rv", {31'b0, rvalid0}, 1);
    chk("fw.rd", rdata0, 32'h11223344);

    // reset during the access cycle of a store
    @(posedge clk); #1;
    drive(0, 1, 2'b10, 0, 12'h050, 32'hAAAAAAAA);
    @(negedge clk);
    chk("rs.gnt", {31'b0, gnt0}, 1);
    @(posedge clk); #1;
    req0 = 0;
    #2 rst_n = 0;
    #1;
    chk("rs.outs", {rvalid0, rvalid1, err0, err1, mem_rd_en, mem_wr_en,
                    gnt0, gnt1}, 0);
    chk("rs.rdata0", rdata0, 0);
    chk("rs.mdin", mem_din, 0);
    @(negedge clk);
    chk("rs.wr", {31'b0, mem_wr_en}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    do_ld("rs.ld", 0, 2'b10, 0, 12'h050, 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
